vcve2_vrf_bank_sync: RTL

- Generalised launch/synchronisation controller for N parallel VRF memory interfaces in the vcve2 vector unit.
- Staggers per-bank start pulses by a programmable skew and runs an N-way latched done-barrier per element round.
- Tracks outstanding memory transactions per bank, gates bank requests at saturation, and aggregates bus errors.
- Sits between the vector ID stage and the per-bank vcve2_vrf_interface FSMs.

---
 rtl/vcve2_pkg.sv | 17 +
 rtl/vcve2_outstanding_cnt.sv | 50 +++++
 rtl/vcve2_vrf_bank_sync.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/vcve2_pkg.sv
// vcve2_pkg: shared types and limits for the vcve2 vector unit.
//   vrf_sync_state_e      - states of the VRF bank launch/sync controller
//   VrfSyncMaxIfs         - largest supported number of VRF banks
//   VrfSyncMaxOutstanding - largest supported outstanding depth per bank
package vcve2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    RUN    = 2'd2,
    DRAIN  = 2'd3
  } vrf_sync_state_e;

  localparam int unsigned VrfSyncMaxIfs         = 8;
  localparam int unsigned VrfSyncMaxOutstanding = 7;

endpackage

// File: rtl/vcve2_outstanding_cnt.sv
// vcve2_outstanding_cnt: outstanding-transaction counter for one VRF bank.
//   clk_i, rst_ni  clock, synchronous active-low reset
//   req_i          raw data_req from the bank FSM
//   gnt_i          memory grant
//   rvalid_i       memory response valid
//   req_o          data_req gated while the bank is saturated
//   idle_o         no transactions outstanding
//   underflow_o    response seen with nothing outstanding (protocol error)
module vcve2_outstanding_cnt import vcve2_pkg::*; #(
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic req_i,
  input  logic gnt_i,
  input  logic rvalid_i,
  output logic req_o,
  output logic idle_o,
  output logic underflow_o
);

  localparam int unsigned CntW = $clog2(MaxOutstanding + 1);

  if (MaxOutstanding < 1 || MaxOutstanding > VrfSyncMaxOutstanding) begin : g_bad_max
    $error("MaxOutstanding out of range");
  end

  logic [CntW-1:0] r_cnt;
  logic            w_inc;
  logic            w_dec;

  assign req_o = req_i & (r_cnt < CntW'(MaxOutstanding));

  // A grant only counts against a request that actually reached memory.
  assign w_inc       = gnt_i & req_o;
  assign w_dec       = rvalid_i;
  assign idle_o      = (r_cnt == '0);
  assign underflow_o = w_dec & ~w_inc & (r_cnt == '0);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_cnt <= '0;
    end else if (w_inc && !w_dec) begin
      r_cnt <= r_cnt + CntW'(1);
    end else if (!w_inc && w_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - CntW'(1);
    end
  end

endmodule

// File: rtl/vcve2_vrf_bank_sync.sv
// vcve2_vrf_bank_sync: launch / round-barrier controller for N VRF banks.
//   start_i, abort_i, skew_i, rounds_i  operation control from the ID stage
//   bank_start_o    staggered one-cycle start pulse per bank
//   bank_done_i     per-bank round done
//   bank_release_o  barrier release pulse to every bank
//   bank_req_i/o, data_gnt_i, data_rvalid_i, data_err_i  memory side, gated
//   agu_load_o, agu_incr_o  address generator control
//   busy_o, all_done_o, err_o, err_bank_o  status
//
// state  | meaning
// IDLE   | waiting for start_i
// LAUNCH | staggering bank starts, barrier already active
// RUN    | all banks started, barrier rounds in progress
// DRAIN  | rounds done, waiting for outstanding transactions to return
module vcve2_vrf_bank_sync import vcve2_pkg::*; #(
  parameter int unsigned NumIfs         = 2,
  parameter int unsigned MaxOutstanding = 2,
  parameter int unsigned SkewW          = 3,
  parameter int unsigned RoundW         = 8,
  localparam int unsigned IdxW          = (NumIfs > 1) ? $clog2(NumIfs) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [SkewW-1:0]  skew_i,
  input  logic [RoundW-1:0] rounds_i,
  output logic [NumIfs-1:0] bank_start_o,
  input  logic [NumIfs-1:0] bank_done_i,
  output logic [NumIfs-1:0] bank_release_o,
  input  logic [NumIfs-1:0] bank_req_i,
  output logic [NumIfs-1:0] bank_req_o,
  input  logic [NumIfs-1:0] data_gnt_i,
  input  logic [NumIfs-1:0] data_rvalid_i,
  input  logic [NumIfs-1:0] data_err_i,
  output logic              agu_load_o,
  output logic              agu_incr_o,
  output logic              busy_o,
  output logic              all_done_o,
  output logic              err_o,
  output logic [IdxW-1:0]   err_bank_o
);

  if (NumIfs < 1 || NumIfs > VrfSyncMaxIfs) begin : g_bad_numifs
    $error("NumIfs out of range");
  end

  vrf_sync_state_e r_state, w_state_nxt;

  logic [SkewW-1:0]  r_skew;
  logic [SkewW-1:0]  r_skew_cnt;
  logic [IdxW-1:0]   r_bank_idx;
  logic [NumIfs-1:0] r_started;
  logic [NumIfs-1:0] r_done;
  logic [RoundW-1:0] r_round_cnt;
  logic [RoundW-1:0] r_rounds;
  logic              r_release;
  logic              r_err;
  logic [IdxW-1:0]   r_err_bank;

  logic [NumIfs-1:0] w_bank_start;
  logic [NumIfs-1:0] w_done_set;
  logic [NumIfs-1:0] w_cnt_idle;
  logic [NumIfs-1:0] w_uflow;
  logic [NumIfs-1:0] w_err_vec;
  logic [IdxW-1:0]   w_err_idx;
  logic              w_start_ok;
  logic              w_barrier;
  logic              w_round_last;
  logic              w_skew_tc;
  logic              w_last_bank;
  logic              w_drained;
  logic              w_all_done;

  for (genvar k = 0; k < NumIfs; k++) begin : g_out
    vcve2_outstanding_cnt #(
      .MaxOutstanding(MaxOutstanding)
    ) u_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .req_i      (bank_req_i[k]),
      .gnt_i      (data_gnt_i[k]),
      .rvalid_i   (data_rvalid_i[k]),
      .req_o      (bank_req_o[k]),
      .idle_o     (w_cnt_idle[k]),
      .underflow_o(w_uflow[k])
    );
  end

  assign w_start_ok  = start_i & ~abort_i & (r_state == IDLE);
  assign w_skew_tc   = (r_skew_cnt == SkewW'(1));
  assign w_last_bank = (r_bank_idx == IdxW'(NumIfs - 1));

  // Dones from banks not yet started are dropped.
  assign w_done_set   = r_done | (bank_done_i & r_started);
  assign w_barrier    = ((r_state == LAUNCH) || (r_state == RUN)) && (&w_done_set) && !abort_i;
  assign w_round_last = w_barrier && ((r_round_cnt + RoundW'(1)) == r_rounds);
  assign w_drained    = (&w_cnt_idle) && !(|(bank_req_o & data_gnt_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_bank_start = '0;
    w_all_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) begin
          if (skew_i == '0) begin
            w_bank_start = '1;
            w_state_nxt  = RUN;
          end else begin
            w_bank_start = NumIfs'(1);
            w_state_nxt  = (NumIfs == 1) ? RUN : LAUNCH;
          end
        end
      end
      LAUNCH: begin
        if (w_skew_tc) begin
          for (int k = 0; k < NumIfs; k++) begin
            if (r_bank_idx == IdxW'(k)) w_bank_start[k] = 1'b1;
          end
          if (w_last_bank) w_state_nxt = RUN;
        end
        if (w_round_last) w_state_nxt = DRAIN;
      end
      RUN: begin
        if (w_round_last) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_drained) begin
          w_all_done  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    if (abort_i) begin
      w_state_nxt  = IDLE;
      w_bank_start = '0;
      w_all_done   = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_skew      <= '0;
      r_skew_cnt  <= '0;
      r_bank_idx  <= '0;
      r_started   <= '0;
      r_done      <= '0;
      r_round_cnt <= '0;
      r_rounds    <= '0;
      r_release   <= 1'b0;
    end else if (abort_i) begin
      r_skew_cnt  <= '0;
      r_bank_idx  <= '0;
      r_started   <= '0;
      r_done      <= '0;
      r_round_cnt <= '0;
      r_release   <= 1'b0;
    end else begin
      r_release <= w_barrier;
      case (r_state)
        IDLE: begin
          if (w_start_ok) begin
            r_skew      <= skew_i;
            r_skew_cnt  <= skew_i;
            r_rounds    <= (rounds_i == '0) ? RoundW'(1) : rounds_i;
            r_bank_idx  <= IdxW'(1);
            r_started   <= w_bank_start;
            r_done      <= '0;
            r_round_cnt <= '0;
          end
        end
        LAUNCH, RUN: begin
          // Skew timer counts down to 1, fires a start, then reloads.
          if (r_state == LAUNCH) begin
            if (w_skew_tc) begin
              r_skew_cnt <= r_skew;
              r_bank_idx <= r_bank_idx + IdxW'(1);
            end else begin
              r_skew_cnt <= r_skew_cnt - SkewW'(1);
            end
          end
          r_started <= r_started | w_bank_start;
          r_done    <= w_barrier ? '0 : w_done_set;
          if (w_barrier) r_round_cnt <= r_round_cnt + RoundW'(1);
        end
        default: ;
      endcase
    end
  end

  assign w_err_vec = (data_err_i & data_rvalid_i) | w_uflow;

  always_comb begin
    w_err_idx = '0;
    for (int k = NumIfs - 1; k >= 0; k--) begin
      if (w_err_vec[k]) w_err_idx = IdxW'(k);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_err      <= 1'b0;
      r_err_bank <= '0;
    end else if (abort_i || w_start_ok) begin
      r_err      <= 1'b0;
      r_err_bank <= '0;
    end else if (|w_err_vec) begin
      r_err <= 1'b1;
      if (!r_err) r_err_bank <= w_err_idx;
    end
  end

  assign bank_start_o   = w_bank_start;
  assign agu_load_o     = w_bank_start[0];
  assign bank_release_o = {NumIfs{r_release}};
  assign agu_incr_o     = r_release;
  assign busy_o         = (r_state != IDLE);
  assign all_done_o     = w_all_done;
  assign err_o          = r_err;
  assign err_bank_o     = r_err_bank;

endmodule
